// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: board timing defaults,
// the repeat-phase type and the counter width helper.
package btn_pkg;

  localparam int DEB_1MS_100MHZ  = 100_000;
  localparam int DEB_10MS_100MHZ = 1_000_000;
  localparam int REPEAT_500MS    = 50_000_000;
  localparam int REPEAT_100MS    = 10_000_000;

  typedef enum logic {
    RPT_DELAY = 1'b0,
    RPT_RATE  = 1'b1
  } rpt_phase_t;

  // Bits needed to hold 0..max_count; never returns zero.
  function automatic int cnt_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: multi-stage synchroniser followed by a stable-count
// debouncer. rise/fall are combinational strobes for the edge on which db changes.
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = DEB_10MS_100MHZ
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   done;

  assign s    = sync[SYNC_STAGES-1];
  assign done = (s != db) && (cnt == CW'(DEB_CYCLES - 1));
  assign rise = done & s;
  assign fall = done & ~s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      // Any sample agreeing with db restarts the count, so glitches vanish.
      if (s == db) begin
        cnt <= '0;
      end else if (done) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: debounce, acceptance arbitration,
// press/release/repeat one-shots and per-channel toggle registers.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = DEB_10MS_100MHZ,
  parameter int REPEAT_DELAY = REPEAT_500MS,
  parameter int REPEAT_RATE  = REPEAT_100MS,
  parameter bit EXCLUSIVE    = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] held_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic [N_BTN-1:0] toggle_o,
  output logic             any_held_o
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = cnt_w(RPT_MAX);

  logic [N_BTN-1:0] db;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] held_nxt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .CLK  (CLK),
      .RESET(RESET),
      .btn  (btn_i[i]),
      .db   (db[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // In exclusive mode the highest-index rise wins, and only when nothing is held.
  always_comb begin
    grant = '0;
    if (!EXCLUSIVE) begin
      grant = rise;
    end else if (held_o == '0) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (rise[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  assign rel      = fall & held_o;
  assign held_nxt = (held_o | grant) & ~rel;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      held_o     <= '0;
      press_o    <= '0;
      release_o  <= '0;
      toggle_o   <= '0;
      any_held_o <= 1'b0;
    end else begin
      held_o     <= held_nxt;
      press_o    <= grant;
      release_o  <= rel;
      toggle_o   <= toggle_o ^ grant;
      any_held_o <= |held_nxt;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_rpt
    if (REPEAT_DELAY == 0) begin : g_off
      assign repeat_o[i] = 1'b0;
    end else begin : g_on
      localparam logic [RPT_W-1:0] DELAY_END = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RATE_END  = RPT_W'(REPEAT_RATE - 1);

      logic [RPT_W-1:0] rcnt;
      logic [RPT_W-1:0] limit;
      rpt_phase_t       phase;
      logic             rpt_q;

      assign limit       = (phase == RPT_DELAY) ? DELAY_END : RATE_END;
      assign repeat_o[i] = rpt_q;

      // Press, release and idle all park the counter in the initial delay phase.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          rcnt  <= '0;
          phase <= RPT_DELAY;
          rpt_q <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (grant[i] || rel[i] || !held_o[i]) begin
            rcnt  <= '0;
            phase <= RPT_DELAY;
          end else if (rcnt == limit) begin
            rpt_q <= 1'b1;
            rcnt  <= '0;
            phase <= RPT_RATE;
          end else begin
            rcnt <= rcnt + RPT_W'(1);
          end
        end
      end
    end
  end

  // An accepted channel is always debounced high.
  assert property (@(posedge CLK) disable iff (RESET) (held_o & ~db) == '0);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: three configurations driven with directed and
// random button patterns, checked every cycle against a window-based model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int RATE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0] btnIn  [3];
  logic [3:0] heldO  [3];
  logic [3:0] pressO [3];
  logic [3:0] relO   [3];
  logic [3:0] rptO   [3];
  logic [3:0] togO   [3];
  logic       anyO   [3];

  int checks = 0;
  int passes = 0;

  // Model state: last six synchroniser-input samples per bench, debounced
  // level, accepted mask, toggles, cycle count and per-channel press cycle.
  logic [3:0] hist    [3][6];
  logic [3:0] mDb     [3];
  logic [3:0] mAcc    [3];
  logic [3:0] mTog    [3];
  logic [3:0] ePress  [3];
  logic [3:0] eRel    [3];
  logic [3:0] eRpt    [3];
  int         mCyc    [3];
  int         pressAt [3][4];
  int         rptDelay  [3] = '{10, 10, 0};
  bit         exclusive [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DEB_CYCLES(DEB), .REPEAT_DELAY(10),
                       .REPEAT_RATE(RATE), .EXCLUSIVE(1'b1)) dut0 (
    .CLK(clk), .RESET(rst), .btn_i(btnIn[0]), .held_o(heldO[0]), .press_o(pressO[0]),
    .release_o(relO[0]), .repeat_o(rptO[0]), .toggle_o(togO[0]), .any_held_o(anyO[0]));

  button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DEB_CYCLES(DEB), .REPEAT_DELAY(10),
                       .REPEAT_RATE(RATE), .EXCLUSIVE(1'b0)) dut1 (
    .CLK(clk), .RESET(rst), .btn_i(btnIn[1]), .held_o(heldO[1]), .press_o(pressO[1]),
    .release_o(relO[1]), .repeat_o(rptO[1]), .toggle_o(togO[1]), .any_held_o(anyO[1]));

  button_conditioner #(.N_BTN(4), .SYNC_STAGES(2), .DEB_CYCLES(DEB), .REPEAT_DELAY(0),
                       .REPEAT_RATE(RATE), .EXCLUSIVE(1'b1)) dut2 (
    .CLK(clk), .RESET(rst), .btn_i(btnIn[2]), .held_o(heldO[2]), .press_o(pressO[2]),
    .release_o(relO[2]), .repeat_o(rptO[2]), .toggle_o(togO[2]), .any_held_o(anyO[2]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int d, input logic [3:0] v);
    btnIn[d] = v;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 6; j++) hist[d][j] = '0;
      for (int c = 0; c < 4; c++) pressAt[d][c] = 0;
      mDb[d] = '0; mAcc[d] = '0; mTog[d] = '0; mCyc[d] = 0;
      ePress[d] = '0; eRel[d] = '0; eRpt[d] = '0;
    end
  endtask

  // A level is accepted once the last DEB synchronised samples all disagree
  // with the current debounced level (samples are raw inputs two edges old).
  task automatic modelStep(input int d);
    logic [3:0] winHi, winLo, rise, fall, grant, rel;
    int age;
    for (int j = 0; j < 5; j++) hist[d][j] = hist[d][j+1];
    hist[d][5] = btnIn[d];
    mCyc[d]++;
    winHi = 4'hF;
    winLo = 4'hF;
    for (int j = 0; j < DEB; j++) begin
      winHi &= hist[d][j];
      winLo &= ~hist[d][j];
    end
    rise = winHi & ~mDb[d];
    fall = winLo & mDb[d];
    mDb[d] = (mDb[d] | rise) & ~fall;
    grant = '0;
    if (!exclusive[d]) grant = rise;
    else if (mAcc[d] == 4'b0) begin
      for (int c = 3; c >= 0; c--) if (rise[c] && grant == 4'b0) grant[c] = 1'b1;
    end
    rel = fall & mAcc[d];
    mAcc[d] = (mAcc[d] | grant) & ~rel;
    mTog[d] ^= grant;
    ePress[d] = grant;
    eRel[d] = rel;
    eRpt[d] = '0;
    for (int c = 0; c < 4; c++) begin
      if (grant[c]) pressAt[d][c] = mCyc[d];
      else if (mAcc[d][c] && rptDelay[d] > 0) begin
        age = mCyc[d] - pressAt[d][c];
        if (age >= rptDelay[d] && ((age - rptDelay[d]) % RATE) == 0) eRpt[d][c] = 1'b1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else for (int d = 0; d < 3; d++) modelStep(d);
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("model%0d.held", d), heldO[d], mAcc[d]);
        checkOutput($sformatf("model%0d.press", d), pressO[d], ePress[d]);
        checkOutput($sformatf("model%0d.release", d), relO[d], eRel[d]);
        checkOutput($sformatf("model%0d.repeat", d), rptO[d], eRpt[d]);
        checkOutput($sformatf("model%0d.toggle", d), togO[d], mTog[d]);
        checkOutput($sformatf("model%0d.any", d), anyO[d], |mAcc[d]);
      end
    end
  end

  initial begin
    logic [3:0] saw;
    logic [3:0] v [3];
    int rptCount;
    bit rptExp;

    for (int d = 0; d < 3; d++) applyStimulus(d, 4'b0);
    waitEdges(3);
    checkOutput("reset.outputs",
                {heldO[0], pressO[0], relO[0], rptO[0], togO[0], 3'b0, anyO[0]}, 32'h0);
    rst = 1'b0;

    // Clean press on ch0 at cycle 0, released at cycle 30.
    waitEdges(1);
    applyStimulus(0, 4'b0001);
    for (int e = 1; e <= 40; e++) begin
      waitEdges(1);
      rptExp = (e >= 16 && e <= 34 && ((e - 16) % 3) == 0);
      checkOutput($sformatf("clean.edge%0d", e),
                  {pressO[0][0], rptO[0][0], relO[0][0], heldO[0][0]},
                  {(e == 6), rptExp, (e == 36), (e >= 6 && e < 36)});
      if (e == 30) applyStimulus(0, 4'b0000);
    end
    checkOutput("clean.toggle", togO[0], 4'b0001);

    // Bouncing ch1 never settles long enough.
    saw = '0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, (c < 20 && ((c / 2) % 2) == 0) ? 4'b0010 : 4'b0000);
      waitEdges(1);
      saw |= pressO[0] | relO[0] | rptO[0] | heldO[0];
    end
    checkOutput("bounce.activity", saw, 4'b0000);
    checkOutput("bounce.toggle", togO[0], 4'b0001);

    // Simultaneous ch3+ch0: ch3 wins, ch0 stays ignored until re-pressed.
    applyStimulus(0, 4'b1001);
    waitEdges(6);
    checkOutput("prio.press", pressO[0], 4'b1000);
    checkOutput("prio.held", heldO[0], 4'b1000);
    applyStimulus(0, 4'b0001);
    saw = '0;
    for (int c = 0; c < 20; c++) begin
      waitEdges(1);
      saw |= pressO[0];
    end
    checkOutput("prio.ignored", saw, 4'b0000);
    checkOutput("prio.heldAfter", heldO[0], 4'b0000);
    applyStimulus(0, 4'b0000);
    waitEdges(10);
    applyStimulus(0, 4'b0001);
    waitEdges(6);
    checkOutput("prio.repress", pressO[0], 4'b0001);
    checkOutput("prio.toggle", togO[0], 4'b1000);
    applyStimulus(0, 4'b0000);
    waitEdges(10);

    // Reset while ch2 is held with repeat running.
    applyStimulus(0, 4'b0100);
    waitEdges(20);
    checkOutput("rst.heldBefore", heldO[0], 4'b0100);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst.async",
                {heldO[0], pressO[0], relO[0], rptO[0], togO[0], 3'b0, anyO[0]}, 32'h0);
    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      waitEdges(1);
      checkOutput($sformatf("rst.press%0d", e), pressO[0], (e == 6) ? 4'b0100 : 4'b0000);
    end
    applyStimulus(0, 4'b0000);
    waitEdges(10);

    // Independent channels.
    applyStimulus(1, 4'b0110);
    waitEdges(6);
    checkOutput("indep.press", pressO[1], 4'b0110);
    checkOutput("indep.toggle1", togO[1], 4'b0110);
    waitEdges(5);
    applyStimulus(1, 4'b0000);
    waitEdges(10);
    applyStimulus(1, 4'b0110);
    waitEdges(6);
    checkOutput("indep.press2", pressO[1], 4'b0110);
    checkOutput("indep.toggle2", togO[1], 4'b0000);
    applyStimulus(1, 4'b0000);
    waitEdges(10);

    // Auto-repeat disabled.
    applyStimulus(2, 4'b0001);
    rptCount = 0;
    for (int c = 0; c < 100; c++) begin
      waitEdges(1);
      rptCount += int'(rptO[2][0]);
    end
    checkOutput("norpt.count", rptCount, 0);
    checkOutput("norpt.held", heldO[2], 4'b0001);
    applyStimulus(2, 4'b0000);
    waitEdges(10);

    // Random button activity on all three configurations.
    for (int d = 0; d < 3; d++) v[d] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(7) == 0) v[d][$urandom_range(3)] ^= 1'b1;
        applyStimulus(d, v[d]);
      end
      if (c == 1500) begin
        rst = 1'b1;
        waitEdges(2);
        rst = 1'b0;
      end
      waitEdges(1);
    end
    for (int d = 0; d < 3; d++) applyStimulus(d, 4'b0000);
    waitEdges(20);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
